ifetch_unit: RTL

Instruction fetch stage of the MIPS core. Holds the PC and fetches 32-bit words from instruction memory over a req/ready handshake. It presents the held instruction split into MIPS fields; imm16 goes straight to the downstream 16-to-32 sign extender. Next-PC selection (sequential, branch, jump, jump-register) is taken when the decode stage consumes the instruction; the branch offset comes back already sign-extended.

---
 rtl/ifetch_unit.sv | 138 +++++++++++++
 1 files changed

// File: rtl/ifetch_unit.sv
// ============================================================================
//  Module   : ifetch_unit
//  Brief    : MIPS instruction fetch stage; PC, imem handshake, field split.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ifetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ready,
   input  logic [31:0] imem_rdata,
   input  logic        stall,
   input  logic        branch_taken,
   input  logic [31:0] branch_offset_ext,
   input  logic        jump,
   input  logic        jr,
   input  logic [31:0] jr_target,
   output logic [31:0] pc,
   output logic [31:0] pc_plus4,
   output logic [31:0] instr,
   output logic        instr_valid,
   output logic [5:0]  opcode,
   output logic [4:0]  rs,
   output logic [4:0]  rt,
   output logic [4:0]  rd,
   output logic [4:0]  shamt,
   output logic [5:0]  funct,
   output logic [15:0] imm16,
   output logic [25:0] target26,
   output logic        jr_misalign
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      HOLD = 2'd2
   } state_t;

   state_t      r_state;
   state_t      w_state_nxt;
   logic [31:0] r_pc;
   logic [31:0] w_pc_nxt;
   logic [31:0] r_instr;
   logic [31:0] w_instr_nxt;
   logic        r_valid;
   logic        w_valid_nxt;
   logic        r_misalign;
   logic        w_misalign_nxt;
   logic [31:0] w_pc_plus4;
   logic [31:0] w_next_pc;
   logic        w_consume;

   assign w_pc_plus4 = r_pc + 32'd4;
   assign w_consume  = (r_state == HOLD) && r_valid && !stall;

   // Redirect priority: jr over jump over branch over sequential.
   always_comb begin
      w_next_pc = w_pc_plus4;
      if (jr) begin
         w_next_pc = {jr_target[31:2], 2'b00};
      end else if (jump) begin
         w_next_pc = {w_pc_plus4[31:28], r_instr[25:0], 2'b00};
      end else if (branch_taken) begin
         w_next_pc = w_pc_plus4 + {branch_offset_ext[29:0], 2'b00};
      end
   end

   always_comb begin
      w_state_nxt    = r_state;
      w_pc_nxt       = r_pc;
      w_instr_nxt    = r_instr;
      w_valid_nxt    = r_valid;
      w_misalign_nxt = 1'b0;
      case (r_state)
         IDLE: begin
            w_state_nxt = REQ;
         end
         REQ: begin
            if (imem_ready) begin
               w_instr_nxt = imem_rdata;
               w_valid_nxt = 1'b1;
               w_state_nxt = HOLD;
            end
         end
         HOLD: begin
            if (w_consume) begin
               w_pc_nxt       = w_next_pc;
               w_valid_nxt    = 1'b0;
               w_misalign_nxt = jr && (|jr_target[1:0]);
               w_state_nxt    = REQ;
            end
         end
         default: begin
            w_state_nxt = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= IDLE;
         r_pc       <= RESET_PC;
         r_instr    <= 32'd0;
         r_valid    <= 1'b0;
         r_misalign <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_pc       <= w_pc_nxt;
         r_instr    <= w_instr_nxt;
         r_valid    <= w_valid_nxt;
         r_misalign <= w_misalign_nxt;
      end
   end

   assign imem_req    = (r_state == REQ);
   assign imem_addr   = r_pc;
   assign pc          = r_pc;
   assign pc_plus4    = w_pc_plus4;
   assign instr       = r_instr;
   assign instr_valid = r_valid;
   assign jr_misalign = r_misalign;
   assign opcode      = r_instr[31:26];
   assign rs          = r_instr[25:21];
   assign rt          = r_instr[20:16];
   assign rd          = r_instr[15:11];
   assign shamt       = r_instr[10:6];
   assign funct       = r_instr[5:0];
   assign imm16       = r_instr[15:0];
   assign target26    = r_instr[25:0];

endmodule

`default_nettype wire
